motors_cmd_queue: RTL
=====================

MOTORS_CMD_QUEUE -- requirements
Module: motors_cmd_queue

Interface
REQ-001 SHALL have parameter PULSE_NUM_X_BITS, default 9: width of X pulse count per command.
REQ-002 SHALL have parameter PULSE_NUM_Y_BITS, default 9: width of Y pulse count per command.
REQ-003 SHALL have parameter DEPTH, default 4: command slots; power of two, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with the ports below.
  clk  in  1  system clock.
  reset  in  1  async active-high reset.
  clk_en  in  1  module enabling clock; all state advances only on clk edges with clk_en=1.
  flush  in  1  discard all queued, not-yet-issued commands.
  push_valid  in  1  producer offers a command.
  push_ready  out  1  queue accepts a command.
  push_pulse_num_x  in  PULSE_NUM_X_BITS  X pulse count.
  push_dir_x  in  1  X direction.
  push_pulse_num_y  in  PULSE_NUM_Y_BITS  Y pulse count.
  push_dir_y  in  1  Y direction.
  push_servo_down  in  1  pen position: 1 = down.
  motors_rdy  in  1  downstream motors controller idle, can take a trigger.
  motors_done  in  1  downstream one-cycle pulse: move finished.
  motors_trigger  out  1  one-cycle start pulse to motors controller.
  pulse_num_x  out  PULSE_NUM_X_BITS  issued X count.
  dir_x  out  1  issued X direction.
  pulse_num_y  out  PULSE_NUM_Y_BITS  issued Y count.
  dir_y  out  1  issued Y direction.
  servo_down  out  1  issued pen position.
  count  out  $clog2(DEPTH)+1  queued, not-yet-issued commands.
  idle  out  1  queue empty and no move in flight.

Function
REQ-005 SHALL accept a push on a clk_en=1 edge when push_valid=1 and push_ready=1; push_ready SHALL equal (count != DEPTH), independent of push_valid and of any same-cycle pop.
REQ-006 SHALL store commands in FIFO order in a circular buffer; read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-007 SHALL not issue a command in the same cycle it is pushed (minimum push-to-trigger latency: 1 clk_en cycle).
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE.
REQ-009 IDLE -> ISSUE when count>0 and motors_rdy=1; on that edge, the head command SHALL be latched into the payload outputs and popped (count decremented).
REQ-010 ISSUE: motors_trigger SHALL be 1 for exactly this one clk_en cycle; next state WAIT_DONE unconditionally.
REQ-011 WAIT_DONE -> IDLE on motors_done=1; motors_done outside WAIT_DONE SHALL be ignored.
REQ-012 Payload outputs SHALL hold the last issued command stable from ISSUE until the next ISSUE.
REQ-013 Simultaneous push and pop SHALL leave count unchanged and store the pushed entry correctly.
REQ-014 flush SHALL zero count and reset pointers on the same edge; a same-cycle push SHALL be dropped; an in-flight move (ISSUE/WAIT_DONE) SHALL not be aborted and SHALL still complete on motors_done.
REQ-015 idle SHALL equal (count==0 and state==IDLE), combinational from registers.
REQ-016 With clk_en=0, state, pointers, count and outputs SHALL hold; motors_trigger SHALL stay at its held value and is qualified downstream by clk_en.

Reset
REQ-017 reset=1 SHALL, asynchronously, set state=IDLE, pointers=0, count=0, motors_trigger=0, pulse_num_x=0, pulse_num_y=0, dir_x=0, dir_y=0, servo_down=0.
REQ-018 Reset mid-move SHALL discard the in-flight command and all queued commands; no trigger SHALL follow reset release until a new push.

Verification
REQ-019 Push (x=100,dir_x=1,y=50,dir_y=0,servo=1), motors_rdy=1 -> trigger one cycle later, outputs match, count returns to 0, idle=0 until motors_done, then idle=1.
REQ-020 Push 4 commands with motors_rdy=0 -> count=4, push_ready=0, fifth push ignored; raise motors_rdy and return done each move -> 4 triggers in push order, one per done.
REQ-021 With count=4 in WAIT_DONE, pulse motors_done while push_valid=1 -> pop on next issue, push accepted only after count<4, no entry lost or duplicated across pointer wrap (issue 10 commands total).
REQ-022 Queue 3 commands, flush during WAIT_DONE -> count=0 next cycle, current move completes on motors_done, no further trigger.
REQ-023 Toggle clk_en at 1-in-4 -> identical trigger/payload sequence to clk_en=1 run, trigger width exactly one enabled cycle.
REQ-024 Assert reset during WAIT_DONE with 2 queued -> all outputs 0 immediately, count=0, late motors_done after release causes no transition.

Source files
------------

// File: rtl/motors_cmd_queue_if.sv
// -----------------------------------------------------------------------------
// motors_cmd_queue_if
// Push channel of the motors command queue: a valid/ready handshake carrying
// one motion command (X/Y pulse counts, X/Y directions, pen position).
//
//   push_valid        producer -> queue   command offered
//   push_ready        queue -> producer   queue has a free slot
//   push_pulse_num_x  producer -> queue   X pulse count
//   push_dir_x        producer -> queue   X direction
//   push_pulse_num_y  producer -> queue   Y pulse count
//   push_dir_y        producer -> queue   Y direction
//   push_servo_down   producer -> queue   pen position, 1 = down
//
// modport master: the command producer.  modport slave: the queue.
// -----------------------------------------------------------------------------
interface motors_cmd_queue_if #(
    parameter int PULSE_NUM_X_BITS = 9,
    parameter int PULSE_NUM_Y_BITS = 9
);
    logic                        push_valid;
    logic                        push_ready;
    logic [PULSE_NUM_X_BITS-1:0] push_pulse_num_x;
    logic                        push_dir_x;
    logic [PULSE_NUM_Y_BITS-1:0] push_pulse_num_y;
    logic                        push_dir_y;
    logic                        push_servo_down;

    modport master (
        output push_valid,
        output push_pulse_num_x,
        output push_dir_x,
        output push_pulse_num_y,
        output push_dir_y,
        output push_servo_down,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_pulse_num_x,
        input  push_dir_x,
        input  push_pulse_num_y,
        input  push_dir_y,
        input  push_servo_down,
        output push_ready
    );
endinterface

// File: rtl/motors_cmd_queue.sv
// -----------------------------------------------------------------------------
// motors_cmd_queue
// Buffers motion commands in a DEPTH-entry circular FIFO and hands them one at
// a time to a downstream motors controller. A command is issued when the
// controller reports motors_rdy; the queue then pulses motors_trigger for one
// enabled cycle, holds the payload stable, and waits for motors_done before
// issuing the next command.
//
// Ports
//   clk             system clock
//   reset           asynchronous active-high reset
//   clk_en          clock enable; all state advances only on enabled edges
//   flush           drop every queued, not-yet-issued command
//   push            command push channel (slave side of motors_cmd_queue_if)
//   motors_rdy      downstream controller idle, may be triggered
//   motors_done     downstream one-cycle pulse: move finished
//   motors_trigger  one-enabled-cycle start pulse to the controller
//   pulse_num_x/dir_x/pulse_num_y/dir_y/servo_down
//                   payload of the last issued command
//   count           queued, not-yet-issued commands
//   idle            queue empty and no move in flight
// -----------------------------------------------------------------------------
module motors_cmd_queue #(
    parameter int PULSE_NUM_X_BITS = 9,
    parameter int PULSE_NUM_Y_BITS = 9,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic                        flush,
    motors_cmd_queue_if.slave           push,
    input  logic                        motors_rdy,
    input  logic                        motors_done,
    output logic                        motors_trigger,
    output logic [PULSE_NUM_X_BITS-1:0] pulse_num_x,
    output logic                        dir_x,
    output logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
    output logic                        dir_y,
    output logic                        servo_down,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PULSE_NUM_X_BITS-1:0] x;
        logic                        dx;
        logic [PULSE_NUM_Y_BITS-1:0] y;
        logic                        dy;
        logic                        servo;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    entry_t             mem [DEPTH];
    entry_t             issued;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               ready;
    logic               do_push;
    logic               do_pop;

    // Ready depends only on the registered count, so a pop on the same edge
    // never makes room for a push early.
    assign ready          = (count != CNT_W'(DEPTH));
    assign push.push_ready = ready;

    // Flush wins over a same-cycle push: the offered command is dropped.
    assign do_push = push.push_valid && ready && !flush;

    // Next-state logic. Issuing uses the registered count, so a command pushed
    // on this edge cannot be issued until the following enabled edge.
    always_comb begin
        next_state = state;
        do_pop     = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && motors_rdy && !flush) begin
                    next_state = ISSUE;
                    do_pop     = 1'b1;
                end
            end
            ISSUE: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (motors_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, pointers, count and issued payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            motors_trigger <= 1'b0;
            issued         <= '0;
        end else if (clk_en) begin
            state          <= next_state;
            // Trigger is high exactly while the FSM sits in ISSUE.
            motors_trigger <= do_pop;
            if (do_pop) begin
                issued <= mem[rd_ptr];
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                // DEPTH is a power of two, so the pointers wrap naturally.
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Command storage. A push and a pop never target the same slot on one
    // edge: a pop needs count>0 and a push needs count<DEPTH, so when both
    // happen the pointers differ.
    always_ff @(posedge clk) begin
        if (clk_en && do_push) begin
            mem[wr_ptr] <= '{
                x:     push.push_pulse_num_x,
                dx:    push.push_dir_x,
                y:     push.push_pulse_num_y,
                dy:    push.push_dir_y,
                servo: push.push_servo_down
            };
        end
    end

    assign pulse_num_x = issued.x;
    assign dir_x       = issued.dx;
    assign pulse_num_y = issued.y;
    assign dir_y       = issued.dy;
    assign servo_down  = issued.servo;

    assign idle = (count == '0) && (state == IDLE);

endmodule
